// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and data access (DM), DM first.
// Latency: request at t, ack at t+k -> mem_req over t+1..t+k, done at t+k+1; errors/zero-width done at t+1.
// Backpressure: requesters hold req until their done pulse; memory stalls via late mem_ack, bounded by the watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_width,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_BUSY = 2'd1;
  localparam logic [1:0] S_DM_BUSY = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // Last watchdog count value before giving up; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              owner_dm;    // which requester the current access/response belongs to
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              lat_we;
  logic [2:0]        lat_width;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  wd_cnt;
  logic              dm_misal;
  logic              wd_expired;

  // Natural alignment of the data access, derived from the width code.
  always_comb begin
    dm_misal = 1'b0;
    case (dm_width)
      3'b001:        dm_misal = |dm_addr[2:0];
      3'b010, 3'b101: dm_misal = |dm_addr[1:0];
      3'b011, 3'b110: dm_misal = dm_addr[0];
      default:       dm_misal = 1'b0;
    endcase
  end

  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // Arbitration FSM: grant in IDLE, hold the port while BUSY, one-cycle response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      owner_dm   <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      lat_we     <= 1'b0;
      lat_width  <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wd_cnt     <= '0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          if (dm_req) begin
            owner_dm <= 1'b1;
            if (dm_width == 3'b000) begin
              state <= S_RESP;
            end else if (dm_misal) begin
              resp_err <= 1'b1;
              state    <= S_RESP;
            end else begin
              lat_we    <= dm_we;
              lat_width <= dm_width;
              lat_addr  <= dm_addr;
              lat_wdata <= dm_wdata;
              state     <= S_DM_BUSY;
            end
          end else if (if_req) begin
            owner_dm <= 1'b0;
            if (|if_addr[1:0]) begin
              resp_err <= 1'b1;
              state    <= S_RESP;
            end else begin
              lat_we    <= 1'b0;
              lat_width <= 3'b010;
              lat_addr  <= if_addr;
              lat_wdata <= '0;
              state     <= S_IF_BUSY;
            end
          end
        end
        S_IF_BUSY, S_DM_BUSY: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (mem_ack) begin
            resp_err <= 1'b0;
            if (lat_we)
              resp_rdata <= '0;
            else if (state == S_DM_BUSY)
              resp_rdata <= mem_rdata;
            else
              resp_rdata <= DATA_W'(mem_rdata[31:0]);
            wd_cnt <= '0;
            state  <= S_RESP;
          end else if (wd_expired) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            wd_cnt     <= '0;
            state      <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign mem_req   = (state == S_IF_BUSY) || (state == S_DM_BUSY);
  assign mem_we    = lat_we;
  assign mem_width = lat_width;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign dm_done  = (state == S_RESP) && owner_dm;
  assign if_done  = (state == S_RESP) && !owner_dm;
  assign dm_err   = dm_done && resp_err;
  assign if_err   = if_done && resp_err;
  assign dm_rdata = dm_done ? resp_rdata : '0;
  assign if_rdata = if_done ? resp_rdata[31:0] : 32'h0;

endmodule
